sprite_motion_locator: RTL and testbench

SPRITE_MOTION_LOCATOR -- requirements
Module: sprite_motion_locator

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_rect_locator.sv | 51 +++++
 rtl/sprite_motion_locator.sv | 163 ++++++++++++++++
 tb/tb_sprite_motion_locator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite motion controller.
//   FIXED_POINT_MULTIPLIER / FIXED_SHIFT : position fixed-point scaling (1/64 pixel)
//   SCREEN_WIDTH / SCREEN_HEIGHT         : visible VGA area in pixels
//   motion_state_t                       : per-frame update sequencer states
package sprite_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FIXED_SHIFT            = 6;
  localparam int SCREEN_WIDTH           = 640;
  localparam int SCREEN_HEIGHT          = 480;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_BOUND = 2'd2
  } motion_state_t;

  function automatic logic signed [31:0] abs_speed(input logic signed [31:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/sprite_rect_locator.sv
// rect_locator: registered hit test of the current VGA pixel against the
// sprite rectangle, plus the pixel's offset inside the sprite.
//   clk, resetN            : clock, async active-low reset
//   pixelX, pixelY         : current VGA pixel
//   topLeftX, topLeftY     : sprite top-left corner in pixels
//   InsideRectangle        : pixel (previous cycle) lies inside the sprite
//   offsetX, offsetY       : pixel minus top-left when inside, else 0
module rect_locator
  import sprite_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 11,
  parameter int OBJECT_HEIGHT_Y = 48
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY
);

  // One extra bit so the right/bottom edge cannot wrap near 2047.
  logic [11:0] right_edge;
  logic [11:0] bottom_edge;
  logic        hit_x;
  logic        hit_y;
  logic        hit;

  assign right_edge  = {1'b0, topLeftX} + 12'(OBJECT_WIDTH_X);
  assign bottom_edge = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT_Y);

  assign hit_x = (pixelX >= topLeftX) && ({1'b0, pixelX} < right_edge);
  assign hit_y = (pixelY >= topLeftY) && ({1'b0, pixelY} < bottom_edge);
  assign hit   = hit_x && hit_y;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= hit;
      offsetX         <= hit ? (pixelX - topLeftX) : 11'd0;
      offsetY         <= hit ? (pixelY - topLeftY) : 11'd0;
    end
  end

endmodule

// File: rtl/sprite_motion_locator.sv
// sprite_motion_locator: moves a sprite once per frame using signed 1/64-pixel
// fixed-point position and speed, bounces it off the screen edges and reports
// whether the current VGA pixel falls inside it.
//   clk, resetN                : clock, async active-low reset
//   pixelX, pixelY             : current VGA pixel
//   startOfFrame               : one-cycle pulse per frame (blanking)
//   pause                      : level, freezes motion
//   reverseX                   : one-cycle pulse, flip X direction at next update
//   offsetX, offsetY           : pixel offset inside sprite (0 when outside)
//   InsideRectangle            : pixel hit, one cycle after the pixel
//   topLeftX, topLeftY         : integer sprite top-left
//
// state   | meaning
// S_IDLE  | waiting for an unpaused startOfFrame
// S_MOVE  | apply pending X flip, add speeds to positions
// S_BOUND | clamp to screen, point speed inward, publish top-left
module sprite_motion_locator
  import sprite_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 11,
  parameter int OBJECT_HEIGHT_Y = 48,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        reverseX,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY
);

  localparam logic signed [31:0] MAX_X_INT  = 32'(SCREEN_WIDTH - OBJECT_WIDTH_X);
  localparam logic signed [31:0] MAX_Y_INT  = 32'(SCREEN_HEIGHT - OBJECT_HEIGHT_Y);
  localparam logic signed [31:0] MAX_X_FIX  = 32'((SCREEN_WIDTH - OBJECT_WIDTH_X) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] MAX_Y_FIX  = 32'((SCREEN_HEIGHT - OBJECT_HEIGHT_Y) * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] INIT_X_FIX = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] INIT_Y_FIX = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);

  motion_state_t      state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d;
  logic signed [31:0] pos_y_q, pos_y_d;
  logic signed [31:0] spd_x_q, spd_x_d;
  logic signed [31:0] spd_y_q, spd_y_d;
  logic               rev_latch_q, rev_latch_d;
  logic [10:0]        top_left_x_q, top_left_x_d;
  logic [10:0]        top_left_y_q, top_left_y_d;
  logic signed [31:0] spd_x_eff;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x_q      <= INIT_X_FIX;
      pos_y_q      <= INIT_Y_FIX;
      spd_x_q      <= 32'(INITIAL_X_SPEED);
      spd_y_q      <= 32'(INITIAL_Y_SPEED);
      rev_latch_q  <= 1'b0;
      top_left_x_q <= 11'(INITIAL_X);
      top_left_y_q <= 11'(INITIAL_Y);
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      spd_x_q      <= spd_x_d;
      spd_y_q      <= spd_y_d;
      rev_latch_q  <= rev_latch_d;
      top_left_x_q <= top_left_x_d;
      top_left_y_q <= top_left_y_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    spd_x_d      = spd_x_q;
    spd_y_d      = spd_y_q;
    top_left_x_d = top_left_x_q;
    top_left_y_d = top_left_y_q;
    spd_x_eff    = spd_x_q;
    // A reverseX pulse is remembered in every state.
    rev_latch_d  = rev_latch_q | reverseX;

    unique case (state_q)
      S_IDLE: begin
        if (startOfFrame && !pause) begin
          state_d = S_MOVE;
        end
      end

      S_MOVE: begin
        spd_x_eff = rev_latch_q ? -spd_x_q : spd_x_q;
        spd_x_d   = spd_x_eff;
        pos_x_d   = pos_x_q + spd_x_eff;
        pos_y_d   = pos_y_q + spd_y_q;
        // The pending flip is consumed; a pulse arriving right now waits
        // for the next frame.
        rev_latch_d = reverseX;
        state_d     = S_BOUND;
      end

      S_BOUND: begin
        // Clamps run after the flip, so a wall always wins over reverseX.
        if (pos_x_q < 0) begin
          pos_x_d = '0;
          spd_x_d = abs_speed(spd_x_q);
        end else if ((pos_x_q >>> FIXED_SHIFT) > MAX_X_INT) begin
          pos_x_d = MAX_X_FIX;
          spd_x_d = -abs_speed(spd_x_q);
        end

        if (pos_y_q < 0) begin
          pos_y_d = '0;
          spd_y_d = abs_speed(spd_y_q);
        end else if ((pos_y_q >>> FIXED_SHIFT) > MAX_Y_INT) begin
          pos_y_d = MAX_Y_FIX;
          spd_y_d = -abs_speed(spd_y_q);
        end

        // Top-left is published only with the clamped value, never the
        // intermediate one from S_MOVE.
        top_left_x_d = pos_x_d[FIXED_SHIFT +: 11];
        top_left_y_d = pos_y_d[FIXED_SHIFT +: 11];
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign topLeftX = top_left_x_q;
  assign topLeftY = top_left_y_q;

  rect_locator #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
  ) u_rect_locator (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (top_left_x_q),
    .topLeftY       (top_left_y_q),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY)
  );

endmodule

// File: tb/tb_sprite_motion_locator.sv
// Self-checking bench for sprite_motion_locator: pixel hit tests through a
// scoreboard queue, frame motion, reverse/pause handling, wall clamp and
// reset in the middle of an update.
module tb_sprite_motion_locator;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        pause = 1'b0;
  logic        reverseX = 1'b0;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        InsideRectangle;

  logic        e_sof = 1'b0;
  logic        e_pause = 1'b0;
  logic        e_rev = 1'b0;
  logic [10:0] e_offX, e_offY, e_tlX, e_tlY;
  logic        e_inside;

  int n_vec = 0;
  int n_err = 0;

  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  sprite_motion_locator dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .pause(pause), .reverseX(reverseX),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .topLeftX(topLeftX), .topLeftY(topLeftY)
  );

  sprite_motion_locator #(.INITIAL_X(625)) dut_edge (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(e_sof), .pause(e_pause), .reverseX(e_rev),
    .offsetX(e_offX), .offsetY(e_offY), .InsideRectangle(e_inside),
    .topLeftX(e_tlX), .topLeftY(e_tlY)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    repeat (4) tick();
  endtask

  task automatic edge_frame();
    e_sof = 1'b1;
    tick();
    e_sof = 1'b0;
    repeat (4) tick();
  endtask

  // Reference hit model: 11 x 48 sprite at (tlx, tly).
  function automatic logic [22:0] hit_model(input int px, input int py, input int tlx, input int tly);
    logic in;
    in = (px >= tlx) && (px < tlx + 11) && (py >= tly) && (py < tly + 48);
    return in ? {1'b1, 11'(px - tlx), 11'(py - tly)} : 23'd0;
  endfunction

  task automatic pixel_probe(input string tag, input int px, input int py, input int tlx, input int tly);
    logic [22:0] e;
    pixelX = 11'(px);
    pixelY = 11'(py);
    exp_q.push_back(hit_model(px, py, tlx, tly));
    tick();
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_in"},   32'(InsideRectangle), 32'(e[22]));
      check_val({tag, "_offx"}, 32'(offsetX),         32'(e[21:11]));
      check_val({tag, "_offy"}, 32'(offsetY),         32'(e[10:0]));
    end
  endtask

  initial begin
    int px_tab[7] = '{285, 291, 280, 290, 279, 285, 285};
    int py_tab[7] = '{190, 190, 185, 232, 190, 184, 233};

    do_reset();

    check_val("rst_tlx",   32'(topLeftX),        32'd280);
    check_val("rst_tly",   32'(topLeftY),        32'd185);
    check_val("rst_in",    32'(InsideRectangle), 32'd0);
    check_val("rst_offx",  32'(offsetX),         32'd0);
    check_val("rst_offy",  32'(offsetY),         32'd0);
    check_val("rst_state", 32'(dut.state_q),     32'(S_IDLE));

    for (int i = 0; i < 7; i++) pixel_probe($sformatf("pix%0d", i), px_tab[i], py_tab[i], 280, 185);

    // Wall clamp on the second instance (starts at x=625).
    check_val("edge_rst_tlx", 32'(e_tlX), 32'd625);
    for (int f = 1; f <= 9; f++) begin
      edge_frame();
      if (f == 7) check_val("edge_f7_tlx", 32'(e_tlX), 32'd629);
      if (f == 8) begin
        check_val("edge_f8_tlx", 32'(e_tlX), 32'd629);
        check_val("edge_f8_spd", 32'(dut_edge.spd_x_q), 32'hFFFF_FFD8);
        check_val("edge_f8_pos", 32'(dut_edge.pos_x_q), 32'd40256);
      end
      if (f == 9) check_val("edge_f9_tlx", 32'(e_tlX), 32'd628);
    end

    // Sixteen unpaused frames move 16*40/64 = 10 px.
    for (int f = 0; f < 16; f++) frame();
    check_val("f16_tlx", 32'(topLeftX), 32'd290);
    check_val("f16_tly", 32'(topLeftY), 32'd185);
    pixel_probe("mv_in",  300, 190, 290, 185);
    pixel_probe("mv_out", 289, 190, 290, 185);

    // reverseX then one frame: 17920 - 40 = 17880 -> 279.
    do_reset();
    reverseX = 1'b1;
    tick();
    reverseX = 1'b0;
    frame();
    check_val("rev_tlx", 32'(topLeftX),    32'd279);
    check_val("rev_pos", 32'(dut.pos_x_q), 32'd17880);

    // reverseX under pause: paused frame does nothing, next frame flips once.
    do_reset();
    pause = 1'b1;
    reverseX = 1'b1;
    tick();
    reverseX = 1'b0;
    frame();
    check_val("pause_tlx", 32'(topLeftX),    32'd280);
    check_val("pause_pos", 32'(dut.pos_x_q), 32'd17920);
    pause = 1'b0;
    frame();
    check_val("unpause_pos", 32'(dut.pos_x_q), 32'd17880);
    frame();
    check_val("single_flip_pos", 32'(dut.pos_x_q), 32'd17840);
    check_val("single_flip_tlx", 32'(topLeftX),    32'd278);

    // Reset asserted while the update is in S_MOVE.
    do_reset();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    repeat (4) tick();
    check_val("abort_tlx",   32'(topLeftX),     32'd280);
    check_val("abort_pos",   32'(dut.pos_x_q),  32'd17920);
    check_val("abort_state", 32'(dut.state_q),  32'(S_IDLE));

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
